mxm_replay_fifo: RTL and testbench

MXM_REPLAY_FIFO -- requirements
Module: mxm_replay_fifo

---
 rtl/mxm_replay_fifo_pkg.sv | 18 +
 rtl/mxm_replay_fifo_if.sv | 27 ++
 rtl/mxm_replay_fifo_sdp_ram.sv | 45 ++++
 rtl/mxm_replay_fifo.sv | 117 +++++++++++
 tb/tb_mxm_replay_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mxm_replay_fifo_pkg.sv
// Shared constants and types for the replay FIFO that feeds X-bus vectors to the MXM array.
package mxm_replay_fifo_pkg;

  localparam int P              = 64;
  localparam int DATA_WIDTH_DEF = P * 2 * 8;
  localparam int DEPTH_DEF      = 512;

  typedef enum logic {
    RAM_BLOCK       = 1'b0,
    RAM_DISTRIBUTED = 1'b1
  } ram_style_e;

  // Default almost-full margin leaves room for 16 in-flight X-bus beats.
  function automatic int prog_full_thresh_def(input int depth);
    return depth - 16;
  endfunction

endpackage

// File: rtl/mxm_replay_fifo_if.sv
// Write/read/status bundle of the replay FIFO; master is the producer/consumer side.
interface mxm_replay_fifo_if #(
  parameter int DATA_WIDTH = mxm_replay_fifo_pkg::DATA_WIDTH_DEF
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  prog_full;
  logic [15:0]           vec_size_minus_1;
  logic                  rd_en;
  logic                  rd_last_rnd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic                  empty;
  logic                  almost_empty;
  logic                  ovf_err;

  modport master (
    output clr, wr_en, din, vec_size_minus_1, rd_en, rd_last_rnd,
    input  prog_full, dout, dout_vld, empty, almost_empty, ovf_err
  );

  modport slave (
    input  clr, wr_en, din, vec_size_minus_1, rd_en, rd_last_rnd,
    output prog_full, dout, dout_vld, empty, almost_empty, ovf_err
  );
endinterface

// File: rtl/mxm_replay_fifo_sdp_ram.sv
// Simple dual-port RAM with one-cycle registered read; read-first on address collision.
module sdp_ram
  import mxm_replay_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int         ADDR_WIDTH = 9,
  parameter ram_style_e RAM_STYLE  = RAM_BLOCK
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  generate
    if (RAM_STYLE == RAM_BLOCK) begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [WORDS];
      logic [DATA_WIDTH-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_reg <= mem[raddr];
      end
      assign rdata = rdata_reg;
    end else begin : g_distributed
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [WORDS];
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic [DATA_WIDTH-1:0] rdata_comb;

      // Asynchronous LUT read captured in fabric flops keeps the same latency.
      assign rdata_comb = mem[raddr];
      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_reg <= rdata_comb;
      end
      assign rdata = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/mxm_replay_fifo.sv
// Vector replay FIFO: each vector is read repeatedly (rounds) and only freed after its final round.
module mxm_replay_fifo
  import mxm_replay_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int         DEPTH            = DEPTH_DEF,
  parameter int         PROG_FULL_THRESH = prog_full_thresh_def(DEPTH),
  parameter ram_style_e RAM_STYLE        = RAM_BLOCK
) (
  input logic              clk,
  input logic              rst_n,
  mxm_replay_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_P = PW'(PROG_FULL_THRESH);

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, base_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next, base_ptr_next;
  logic [15:0]   elem_cnt_reg, elem_cnt_next;
  logic          dout_vld_reg, empty_reg, almost_empty_reg, prog_full_reg, ovf_err_reg;

  logic [PW-1:0] occupancy, unread, occupancy_next, unread_next;
  logic          full, wr_acc, wr_drop, rd_acc, size_err, round_end;
  logic [DATA_WIDTH-1:0] ram_q;

  // Occupancy counts from base_ptr: entries still owed to a replay cannot be overwritten.
  assign occupancy = wr_ptr_reg - base_ptr_reg;
  assign unread    = wr_ptr_reg - rd_ptr_reg;
  assign full      = (occupancy == DEPTH_P);
  assign wr_acc    = bus.wr_en && !full && !bus.clr;
  assign wr_drop   = bus.wr_en && full && !bus.clr;
  assign rd_acc    = bus.rd_en && (unread != '0) && !bus.clr;
  assign size_err  = (32'(bus.vec_size_minus_1) >= 32'(DEPTH));
  assign round_end = (elem_cnt_reg == bus.vec_size_minus_1);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    base_ptr_next = base_ptr_reg;
    elem_cnt_next = elem_cnt_reg;
    if (bus.clr) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      base_ptr_next = '0;
      elem_cnt_next = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_acc) begin
        if (round_end) begin
          elem_cnt_next = '0;
          if (bus.rd_last_rnd) begin
            rd_ptr_next   = rd_ptr_reg + 1'b1;
            base_ptr_next = rd_ptr_reg + 1'b1;
          end else begin
            rd_ptr_next = base_ptr_reg;
          end
        end else begin
          rd_ptr_next   = rd_ptr_reg + 1'b1;
          elem_cnt_next = elem_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign occupancy_next = wr_ptr_next - base_ptr_next;
  assign unread_next    = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      base_ptr_reg     <= '0;
      elem_cnt_reg     <= '0;
      dout_vld_reg     <= 1'b0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      prog_full_reg    <= 1'b0;
      ovf_err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      base_ptr_reg     <= base_ptr_next;
      elem_cnt_reg     <= elem_cnt_next;
      dout_vld_reg     <= rd_acc;
      empty_reg        <= (unread_next == '0);
      almost_empty_reg <= (unread_next <= PW'(1));
      prog_full_reg    <= (occupancy_next >= THRESH_P);
      if (wr_drop || size_err) ovf_err_reg <= 1'b1;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW),
    .RAM_STYLE  (RAM_STYLE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (ram_q)
  );

  // RAM output has no reset, so dout is forced to zero whenever it is not valid.
  assign bus.dout         = dout_vld_reg ? ram_q : '0;
  assign bus.dout_vld     = dout_vld_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.prog_full    = prog_full_reg;
  assign bus.ovf_err      = ovf_err_reg;

endmodule

// File: tb/tb_mxm_replay_fifo.sv
// Directed scoreboard bench for mxm_replay_fifo: replay, wrap, overflow, clear and reset cases.
module tb_mxm_replay_fifo;
  import mxm_replay_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mxm_replay_fifo_if #(.DATA_WIDTH(DW)) bus ();

  mxm_replay_fifo #(
    .DATA_WIDTH       (DW),
    .DEPTH            (DEPTH),
    .PROG_FULL_THRESH (THR),
    .RAM_STYLE        (RAM_BLOCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid output beat is matched against the next expected word.
  always @(negedge clk) begin
    if (rst_n && bus.dout_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dout_unexpected: got %h, expected no valid beat", bus.dout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("dout", bus.dout, e);
        $display("beat dout=%h exp=%h", bus.dout, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr         = 1'b0;
    bus.wr_en       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rd_last_rnd = 1'b0;
  endtask

  task automatic write(input logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.din   = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic read(input logic last, input logic [DW-1:0] d);
    bus.rd_en       = 1'b1;
    bus.rd_last_rnd = last;
    exp_q.push_back(d);
    cyc();
    bus.rd_en       = 1'b0;
    bus.rd_last_rnd = 1'b0;
  endtask

  initial begin
    idle();
    bus.din              = '0;
    bus.vec_size_minus_1 = 16'd0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Reset state
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    check("rst_prog_full", 32'(bus.prog_full), 32'd0);
    check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
    check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("rst_dout", bus.dout, 32'd0);

    // Early read on empty FIFO
    bus.rd_en = 1'b1;
    bus.rd_last_rnd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("early_dout_vld", 32'(bus.dout_vld), 32'd0);
      check("early_empty", 32'(bus.empty), 32'd1);
    end
    idle();
    write(32'hE000_0000);
    check("early_one_unread", 32'({bus.empty, bus.almost_empty}), 32'b01);
    read(1'b1, 32'hE000_0000);
    check("early_drained", 32'(bus.empty), 32'd1);

    // Replay: 4-entry vector, two replays then final round
    bus.vec_size_minus_1 = 16'd3;
    for (int i = 0; i < 4; i++) write(32'hA000_0000 + 32'(i));
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 4; e++) begin
        // Non-final reads carry the opposite rd_last_rnd to show it is ignored there.
        read((e == 3) ? (r == 2) : (r != 2), 32'hA000_0000 + 32'(e));
      end
    end
    check("replay_empty", 32'(bus.empty), 32'd1);
    check("replay_prog_full", 32'(bus.prog_full), 32'd0);

    // Wrap: 40 single-entry vectors through a 16-deep FIFO
    bus.vec_size_minus_1 = 16'd0;
    for (int i = 0; i < 20; i++) begin
      write(32'hB000_0000 + 32'(2 * i));
      write(32'hB000_0000 + 32'(2 * i + 1));
      read(1'b1, 32'hB000_0000 + 32'(2 * i));
      read(1'b1, 32'hB000_0000 + 32'(2 * i + 1));
    end
    check("wrap_ovf_err", 32'(bus.ovf_err), 32'd0);
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Simultaneous write and read with one unread entry
    write(32'hC000_0000);
    check("sim_first_flags", 32'({bus.empty, bus.almost_empty}), 32'b01);
    for (int i = 1; i <= 8; i++) begin
      bus.din         = 32'hC000_0000 + 32'(i);
      bus.wr_en       = 1'b1;
      bus.rd_en       = 1'b1;
      bus.rd_last_rnd = 1'b1;
      exp_q.push_back(32'hC000_0000 + 32'(i - 1));
      cyc();
      check("sim_flags", 32'({bus.empty, bus.almost_empty}), 32'b01);
    end
    idle();
    read(1'b1, 32'hC000_0008);
    check("sim_drained", 32'(bus.empty), 32'd1);

    // Clear mid-round after 2 of 4 reads
    bus.vec_size_minus_1 = 16'd3;
    for (int i = 0; i < 4; i++) write(32'hD000_0000 + 32'(i));
    read(1'b0, 32'hD000_0000);
    read(1'b0, 32'hD000_0001);
    bus.clr   = 1'b1;
    bus.wr_en = 1'b1;
    bus.din   = 32'hDEAD_BEEF;
    bus.rd_en = 1'b1;
    cyc();
    idle();
    check("clr_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("clr_empty", 32'(bus.empty), 32'd1);
    write(32'hD100_0000);
    check("clr_restart_flags", 32'({bus.empty, bus.almost_empty}), 32'b01);
    for (int i = 1; i < 4; i++) write(32'hD100_0000 + 32'(i));
    for (int i = 0; i < 4; i++) read(i == 3, 32'hD100_0000 + 32'(i));
    check("clr_after_empty", 32'(bus.empty), 32'd1);
    check("clr_ovf_err", 32'(bus.ovf_err), 32'd0);

    // Overflow: 17 writes into 16 entries
    bus.vec_size_minus_1 = 16'd0;
    for (int k = 1; k <= 17; k++) begin
      write(32'hF000_0000 + 32'(k - 1));
      if (k == 11) check("pf_below_thresh", 32'(bus.prog_full), 32'd0);
      if (k == 12) check("pf_at_thresh", 32'(bus.prog_full), 32'd1);
      if (k == 16) check("ovf_at_full", 32'(bus.ovf_err), 32'd0);
    end
    check("ovf_set", 32'(bus.ovf_err), 32'd1);
    check("ovf_prog_full", 32'(bus.prog_full), 32'd1);
    for (int i = 0; i < 16; i++) read(1'b1, 32'hF000_0000 + 32'(i));
    check("ovf_drained", 32'(bus.empty), 32'd1);
    check("ovf_sticky", 32'(bus.ovf_err), 32'd1);

    // Reset while a read is in flight
    write(32'h9000_0000);
    write(32'h9000_0001);
    bus.rd_en       = 1'b1;
    bus.rd_last_rnd = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    #1;
    check("mid_rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("mid_rst_ovf_err", 32'(bus.ovf_err), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_dout", bus.dout, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    write(32'h9100_0000);
    read(1'b1, 32'h9100_0000);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

    // Vector size limit
    bus.vec_size_minus_1 = 16'd15;
    cyc();
    check("vsize_max_ok", 32'(bus.ovf_err), 32'd0);
    bus.vec_size_minus_1 = 16'd16;
    cyc();
    check("vsize_over", 32'(bus.ovf_err), 32'd1);

    repeat (3) cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
